// File: rtl/adder_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : adder_axil_slave
// Brief    : AXI4-Lite responder for the adder peripheral. Holds two operand
//            registers, a control/status register and a registered 33-bit
//            sum (32-bit result plus carry out).
// Revision : 1.0 - initial release
// ============================================================================
module adder_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam logic [1:0] c_w_idle    = 2'd0;
  localparam logic [1:0] c_w_have_aw = 2'd1;
  localparam logic [1:0] c_w_have_w  = 2'd2;
  localparam logic [1:0] c_w_resp    = 2'd3;

  localparam logic       c_r_idle    = 1'b0;
  localparam logic       c_r_resp    = 1'b1;

  localparam logic [1:0] c_sel_opa   = 2'd0;
  localparam logic [1:0] c_sel_opb   = 2'd1;
  localparam logic [1:0] c_sel_ctrl  = 2'd2;
  localparam logic [1:0] c_sel_res   = 2'd3;

  logic [1:0]                      r_wstate, w_wstate_nx;
  logic                            r_rstate, w_rstate_nx;
  logic [1:0]                      r_awsel;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]                      r_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_opa, r_opb, r_result, r_cap_a, r_cap_b;
  logic                            r_done, r_carry, r_pend;

  logic                            w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_start;
  logic [1:0]                      w_wsel;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_wdata, w_opa_nx, w_opb_nx, w_rd_mux;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_wstrb;
  logic [C_S_AXI_DATA_WIDTH:0]     w_sum;
  logic                            w_unused;

  // Byte-lane merge of new write data into an existing register value
  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] f_merge(
    input logic [C_S_AXI_DATA_WIDTH-1:0]   old_v,
    input logic [C_S_AXI_DATA_WIDTH-1:0]   new_v,
    input logic [C_S_AXI_DATA_WIDTH/8-1:0] strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] v;
    v = old_v;
    for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) begin
      if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
    end
    return v;
  endfunction

  // Protection bits and the sub-word/upper address bits carry no meaning here
  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The commit uses whichever channel values arrive this cycle, else the latched ones
  assign w_wsel  = w_aw_hs ? S_AXI_AWADDR[3:2] : r_awsel;
  assign w_wdata = w_w_hs  ? S_AXI_WDATA       : r_wdata;
  assign w_wstrb = w_w_hs  ? S_AXI_WSTRB       : r_wstrb;

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wstate <= c_w_idle;
    else        r_wstate <= w_wstate_nx;
  end

  // Write FSM next state and commit decision
  always_comb begin
    w_wstate_nx = r_wstate;
    w_commit    = 1'b0;
    case (r_wstate)
      c_w_idle: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit    = 1'b1;
          w_wstate_nx = c_w_resp;
        end else if (w_aw_hs) begin
          w_wstate_nx = c_w_have_aw;
        end else if (w_w_hs) begin
          w_wstate_nx = c_w_have_w;
        end
      end
      c_w_have_aw: begin
        if (w_w_hs) begin
          w_commit    = 1'b1;
          w_wstate_nx = c_w_resp;
        end
      end
      c_w_have_w: begin
        if (w_aw_hs) begin
          w_commit    = 1'b1;
          w_wstate_nx = c_w_resp;
        end
      end
      default: begin
        if (S_AXI_BREADY) w_wstate_nx = c_w_idle;
      end
    endcase
  end

  // Write FSM outputs; readies are forced low while reset is asserted
  always_comb begin
    S_AXI_AWREADY = !ARESET && (r_wstate == c_w_idle || r_wstate == c_w_have_w);
    S_AXI_WREADY  = !ARESET && (r_wstate == c_w_idle || r_wstate == c_w_have_aw);
    S_AXI_BVALID  = (r_wstate == c_w_resp);
  end

  assign S_AXI_BRESP = r_bresp;

  // Latch each write channel on its own handshake; capture the response at commit
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awsel <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bresp <= 2'b00;
    end else begin
      if (w_aw_hs) r_awsel <= S_AXI_AWADDR[3:2];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= (w_wsel == c_sel_res) ? 2'b10 : 2'b00;
    end
  end

  assign w_opa_nx = (w_commit && w_wsel == c_sel_opa) ? f_merge(r_opa, w_wdata, w_wstrb) : r_opa;
  assign w_opb_nx = (w_commit && w_wsel == c_sel_opb) ? f_merge(r_opb, w_wdata, w_wstrb) : r_opb;
  assign w_start  = w_commit && (w_wsel == c_sel_ctrl) && w_wstrb[0] && w_wdata[0];
  assign w_sum    = {1'b0, r_cap_a} + {1'b0, r_cap_b};

  // Operand registers and the one-cycle adder pipeline
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_cap_a  <= '0;
      r_cap_b  <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_opa <= w_opa_nx;
      r_opb <= w_opb_nx;
      if (w_start) begin
        // A start while a compute is pending simply restarts it
        r_cap_a <= w_opa_nx;
        r_cap_b <= w_opb_nx;
        r_pend  <= 1'b1;
        r_done  <= 1'b0;
      end else if (r_pend) begin
        {r_carry, r_result} <= w_sum;
        r_done <= 1'b1;
        r_pend <= 1'b0;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rstate <= c_r_idle;
    else        r_rstate <= w_rstate_nx;
  end

  // Read FSM next state
  always_comb begin
    w_rstate_nx = r_rstate;
    if (r_rstate == c_r_idle) begin
      if (w_ar_hs) w_rstate_nx = c_r_resp;
    end else if (S_AXI_RREADY) begin
      w_rstate_nx = c_r_idle;
    end
  end

  // Read FSM outputs
  always_comb begin
    S_AXI_ARREADY = !ARESET && (r_rstate == c_r_idle);
    S_AXI_RVALID  = (r_rstate == c_r_resp);
  end

  assign S_AXI_RRESP = 2'b00;
  assign S_AXI_RDATA = r_rdata;

  // Register-file view as seen at the AR handshake edge (pre-update values)
  always_comb begin
    w_rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      c_sel_opa:  w_rd_mux = r_opa;
      c_sel_opb:  w_rd_mux = r_opb;
      c_sel_ctrl: w_rd_mux = {{(C_S_AXI_DATA_WIDTH-3){1'b0}}, r_carry, r_done, 1'b0};
      default:    w_rd_mux = r_result;
    endcase
  end

  // Read data is captured on the address handshake and held until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)       r_rdata <= '0;
    else if (w_ar_hs) r_rdata <= w_rd_mux;
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_axil_slave
// Brief    : Self-checking bench for adder_axil_slave with a transaction-level
//            register model, directed corner cases and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_axil_slave;

  logic        clk = 1'b0;
  logic        arst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int checks   = 0;
  int failures = 0;

  // Model of the register file at transaction level
  logic [31:0] m_opa, m_opb, m_result;
  logic        m_done, m_carry;

  // Expectations consumed by the per-cycle compare process
  logic        b_expect = 1'b0;
  logic        r_expect = 1'b0;
  logic [1:0]  exp_bresp = 2'b00;
  logic [31:0] exp_rdata = '0;

  adder_axil_slave dut (
    .ACLK          (clk),
    .ARESET        (arst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_opa;
      2'd1:    return m_opb;
      2'd2:    return {29'b0, m_carry, m_done, 1'b0};
      default: return m_result;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [32:0] sum;
    resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (s[i] && a[3:2] == 2'd0) m_opa[8*i +: 8] = d[8*i +: 8];
      if (s[i] && a[3:2] == 2'd1) m_opb[8*i +: 8] = d[8*i +: 8];
    end
    if (a[3:2] == 2'd2 && s[0] && d[0]) begin
      sum      = {1'b0, m_opa} + {1'b0, m_opb};
      m_result = sum[31:0];
      m_carry  = sum[32];
      m_done   = 1'b1;
    end
    if (a[3:2] == 2'd3) resp = 2'b10;
  endtask

  task automatic model_reset();
    m_opa = '0; m_opb = '0; m_result = '0; m_done = 1'b0; m_carry = 1'b0;
  endtask

  // Every cycle a response is presented it must match the model's expectation
  always @(negedge clk) begin
    if (!arst) begin
      if (bvalid) begin
        chk("b_expected", b_expect, 1);
        chk("bresp", bresp, exp_bresp);
        chk("b_readies_low", {awready, wready}, 2'b00);
      end
      if (rvalid) begin
        chk("r_expected", r_expect, 1);
        chk("rdata", rdata, exp_rdata);
        chk("rresp", rresp, 2'b00);
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd, output logic [1:0] resp);
    int c;
    bit aw_done, w_done, aw_hs, w_hs;
    c = 0; aw_done = 0; w_done = 0;
    model_write(a, d, s, exp_bresp);
    b_expect = 1'b1;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (c >= awd);
      wvalid  = !w_done  && (c >= wd);
      @(negedge clk);
      if (aw_done) begin
        chk("have_aw_awready", awready, 0);
        chk("have_aw_wready", wready, 1);
      end
      if (w_done) begin
        chk("have_w_wready", wready, 0);
        chk("have_w_awready", awready, 1);
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      c++;
      if (c > 60 && !(aw_done && w_done)) begin
        fail_now("write_handshake");
        break;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_latency", bvalid, 1);
    resp = bresp;
    repeat (bd) begin @(posedge clk); #1; end
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0;
    b_expect = 1'b0;
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int ard, input int rd, output logic [31:0] data);
    int c;
    bit hs;
    exp_rdata = model_read(a);
    r_expect = 1'b1;
    repeat (ard) begin @(posedge clk); #1; end
    arvalid = 1'b1; araddr = a; c = 0; hs = 0;
    while (!hs) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      c++;
      if (!hs && c > 60) begin
        fail_now("read_handshake");
        break;
      end
    end
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1);
    data = rdata;
    repeat (rd) begin @(posedge clk); #1; end
    rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rready = 1'b0;
    r_expect = 1'b0;
    chk("rvalid_drop", rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, d;
    logic [3:0]  a, s;
    logic        old_carry;

    arst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    model_reset();

    // Reset state
    #3;
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_bresp", bresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    #1 chk("idle_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // Sequential writes of the whole map
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, resp); chk("bresp_opa_lit", resp, 2'b00);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0, resp); chk("bresp_opb_lit", resp, 2'b00);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0, resp); chk("bresp_ctrl_lit", resp, 2'b00);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0, resp); chk("bresp_res_lit", resp, 2'b10);
    axi_read(4'h0, 0, 0, rd); chk("opa_lit", rd, 32'h1);
    axi_read(4'h4, 0, 0, rd); chk("opb_lit", rd, 32'h2);
    axi_read(4'h8, 0, 0, rd); chk("ctrl_lit", rd, 32'h2);
    axi_read(4'hC, 0, 0, rd); chk("result_lit", rd, 32'h3);

    // Wrap-around with carry out
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
    axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0, resp);
    axi_write(4'h8, 32'h1, 4'hF, 0, 0, 0, resp);
    axi_read(4'hC, 0, 0, rd); chk("wrap_result_lit", rd, 32'h0);
    axi_read(4'h8, 0, 0, rd); chk("wrap_ctrl_lit", rd, 32'h6);

    // Data ahead of address, then held responses
    axi_write(4'h0, 32'h1234_5678, 4'hF, 3, 0, 0, resp);
    axi_write(4'h0, 32'h0BAD_F00D, 4'hF, 0, 2, 5, resp);
    axi_read(4'h0, 0, 5, rd); chk("held_read_lit", rd, 32'h0BAD_F00D);

    // Byte strobes
    axi_write(4'h0, 32'hAABB_CCDD, 4'hF, 0, 0, 0, resp);
    axi_write(4'h0, 32'h1122_3344, 4'h5, 0, 0, 0, resp);
    axi_read(4'h0, 0, 0, rd); chk("strobe_lit", rd, 32'hAA22_CC44);

    // Read and write of OPB commit on the same edge: read sees the old value
    exp_rdata = m_opb;
    r_expect = 1'b1;
    model_write(4'h4, 32'h5A5A_0F0F, 4'hF, exp_bresp);
    b_expect = 1'b1;
    awaddr = 4'h4; wdata = 32'h5A5A_0F0F; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    chk("conc_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("conc_valids", {bvalid, rvalid}, 2'b11);
    chk("conc_old_lit", rdata, 32'h1);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0; b_expect = 0; r_expect = 0;
    chk("conc_drop", {bvalid, rvalid}, 2'b00);
    axi_read(4'h4, 0, 0, rd); chk("conc_new_lit", rd, 32'h5A5A_0F0F);

    // CTRL read landing on the adder completion edge sees DONE=0
    old_carry = m_carry;
    exp_rdata = {29'b0, old_carry, 2'b00};
    model_write(4'h8, 32'h1, 4'h1, exp_bresp);
    b_expect = 1'b1;
    awaddr = 4'h8; wdata = 32'h1; wstrb = 4'h1;
    awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    chk("start_b_latency", bvalid, 1);
    r_expect = 1'b1;
    araddr = 4'h8; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    chk("race_rvalid", rvalid, 1);
    chk("race_ctrl_lit", rdata, 32'h4);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0; b_expect = 0; r_expect = 0;
    axi_read(4'h8, 0, 0, rd); chk("race_after_lit", rd, 32'h6);
    axi_read(4'hC, 0, 0, rd); chk("race_result_lit", rd, 32'h047C_DB53);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), rd);
      end else begin
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF;
        if (a[3:2] == 2'd2 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
      end
    end

    // Reset while the write FSM holds an address without data
    awaddr = 4'h0; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    chk("mid_aw_state", {awready, wready}, 2'b01);
    #2 arst = 1'b1;
    #1 chk("async_drop", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    model_reset();
    @(posedge clk); #1 arst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("no_stray_bvalid", bvalid, 0);
    axi_read(4'h0, 0, 0, rd); chk("post_rst_opa", rd, 0);
    axi_read(4'h4, 0, 0, rd); chk("post_rst_opb", rd, 0);
    axi_read(4'h8, 0, 0, rd); chk("post_rst_ctrl", rd, 0);
    axi_read(4'hC, 0, 0, rd); chk("post_rst_result", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_axil_slave.md
Name: adder_axil_slave

Overview:
- AXI4-Lite responder (slave) for the adder peripheral. Serves register accesses issued by the AXI VIP master in the block design.
- Holds two operand registers and a control/status register. Computes a registered 32-bit sum with carry out.
- Exposes four word-aligned 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Independent write (AW/W/B) and read (AR/R) state machines.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width. Decode uses addr[3:2]; upper bits are ignored.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; asynchronous, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.

Behaviour:
- Register map:
  - 0x0 OPA: RW.
  - 0x4 OPB: RW.
  - 0x8 CTRL: bit0 START (write-1 pulse, always reads 0); bit1 DONE (RO); bit2 CARRY (RO); bits 31:3 read 0.
  - 0xC RESULT: RO.
- Reset (asynchronous, ARESET=1): all registers 0; all READY and VALID outputs 0; BRESP=0; RRESP=0; RDATA=0; both FSMs return to IDLE.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and register contents are cleared.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: AWREADY=WREADY=1. Each channel's address/data is latched on its own handshake.
    - AW and W in the same cycle: commit the write and go to RESP next cycle.
    - AW only: go to HAVE_AW, with AWREADY=0 and WREADY=1.
    - W only: go to HAVE_W, with WREADY=0 and AWREADY=1.
  - HAVE_AW / HAVE_W: commit when the missing channel handshakes, then go to RESP.
  - RESP: BVALID=1; AWREADY=WREADY=0. Hold BVALID and BRESP until BREADY=1, then return to IDLE.
  - Latency: BVALID asserts 1 cycle after the last of AW/W handshakes.
- Write commit:
  - Applied per byte lane, only where WSTRB[n]=1.
  - A write to 0xC changes nothing and returns BRESP=2'b10 (SLVERR). All other offsets return 2'b00.
  - A write to CTRL with WSTRB[0]=1 and WDATA[0]=1 starts the adder; other CTRL bits are ignored.
- Adder:
  - On the start commit cycle: OPA and OPB values are captured (post-write values), and DONE is cleared.
  - The following cycle: RESULT={sum}[31:0], CARRY=sum[32], DONE=1.
  - DONE stays 1 until the next start.
  - A start issued while the compute cycle is pending restarts the operation with the current operands.
  - Wrap-around: 0xFFFFFFFF+1 gives RESULT=0, CARRY=1.
- Read FSM states: IDLE, RESP.
  - IDLE: ARREADY=1. On AR handshake, RDATA is sampled from the register-file state at that edge, and the FSM goes to RESP.
  - RESP: RVALID=1; ARREADY=0. RDATA and RRESP are held stable until RREADY=1, then return to IDLE. RRESP is always 2'b00.
  - Latency: RVALID asserts 1 cycle after the AR handshake.
- Simultaneous events:
  - A read and a write to the same register that commit at the same edge: the read returns the old value.
  - A read of CTRL/RESULT on the same edge the adder completes: the read returns the pre-completion values (DONE=0).
  - The read and write channels operate fully concurrently.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC in sequence (WSTRB=0xF) -> BRESP OKAY, OKAY, OKAY, SLVERR. Reads of OPA=0x1 and OPB=0x2. CTRL reads 0x2 (start pulse dropped, DONE=1). RESULT reads 0x3.
- OPA=0xFFFFFFFF, OPB=0x1, then write CTRL=0x1 -> RESULT=0x0, CTRL=0x6 (CARRY and DONE set).
- W presented 3 cycles before AW, then AW: HAVE_W state with WREADY=0 -> single commit; BVALID 1 cycle after AW handshake.
- Hold BREADY=0 for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout. Hold RREADY=0 for 5 cycles -> RDATA stable.
- Write OPA=0xAABBCCDD, then write 0x11223344 with WSTRB=0x5 -> OPA reads 0xAA22CC44.
- Assert ARESET for 1 cycle mid-AW (HAVE_AW state) -> all VALID/READY outputs drop asynchronously; all registers read 0 afterwards; no stray BVALID.
